// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the rv32i front end.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   if_state_e       : fetch controller states (BOOT, RUN, FLUSH)
//   fetch_entry_t    : one buffered instruction word with its PC
package core_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead synchronous FIFO with a synchronous flush.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : empties the FIFO; overrides push and pop that cycle
//   push, push_data   : write port
//   pop               : advance the head (ignored when empty)
//   head_data         : current head entry (valid when !empty)
//   count, empty      : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; stale contents are never observed because
  // the head is only meaningful while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];

  // The fetch credit scheme guarantees space; a push into a full FIFO is a bug upstream.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && full));
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: rv32i front end. Owns the PC, issues word reads to
// instruction memory, buffers returned words with their PC, and presents
// them to decode. Redirects flush buffered and in-flight fetches.
//   i_clk, i_rst                      : clock, asynchronous active-high reset
//   o_im_req_valid/i_im_req_ready     : memory request handshake
//   o_im_addr                         : word-aligned fetch address
//   i_im_rvalid/i_im_rdata            : in-order read response
//   i_redirect_valid/i_redirect_pc    : one-cycle redirect pulse and target
//   o_if_valid/i_if_ready             : decode handshake on the head entry
//   o_if_instr/o_if_pc                : head instruction and its PC
//   o_misaligned                      : one-cycle flag for a misaligned redirect target
module instruction_fetch
  import core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_im_req_valid,
  input  logic            i_im_req_ready,
  output logic [XLEN-1:0] o_im_addr,
  input  logic            i_im_rvalid,
  input  logic [XLEN-1:0] i_im_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  output logic            o_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  if_state_e       state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic            misaligned_reg, misaligned_next;

  logic            req_fire;
  logic            rsp_keep;
  logic            pop_fire;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   data_count;
  logic [CW-1:0]   tag_count;
  logic            data_empty;
  logic            tag_empty;
  logic [XLEN-1:0] tag_head;
  logic [EW-1:0]   head_bits;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Requests are throttled so every accepted request has a guaranteed buffer slot.
  assign credit_used    = {1'b0, outstanding_reg} + {1'b0, data_count};
  assign o_im_req_valid = (state_reg == RUN) && (credit_used < (CW+1)'(DEPTH));
  assign o_im_addr      = pc_reg;
  assign req_fire       = o_im_req_valid && i_im_req_ready;

  // A response is kept only when nothing stale is still in flight.
  assign rsp_keep = i_im_rvalid && (drop_reg == '0) && !tag_empty;

  assign o_if_valid = !data_empty;
  assign pop_fire   = o_if_valid && i_if_ready;
  assign head_entry = head_bits;
  assign o_if_instr = o_if_valid ? XLEN'(head_entry.instr) : '0;
  assign o_if_pc    = o_if_valid ? XLEN'(head_entry.pc) : '0;
  assign o_misaligned = misaligned_reg;

  always_comb begin
    push_entry       = '0;
    push_entry.instr = XLEN_DEFAULT'(i_im_rdata);
    push_entry.pc    = XLEN_DEFAULT'(tag_head);
  end

  // Address of every accepted request, paired with its in-order response.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_redirect_valid),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_keep),
    .head_data (tag_head),
    .count     (tag_count),
    .empty     (tag_empty)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop_fire),
    .head_data (head_bits),
    .count     (data_count),
    .empty     (data_empty)
  );

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_fire && !i_im_rvalid) begin
      outstanding_next = outstanding_reg + CW'(1);
    end else if (!req_fire && i_im_rvalid && (outstanding_reg != '0)) begin
      outstanding_next = outstanding_reg - CW'(1);
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drop_next       = drop_reg;
    misaligned_next = 1'b0;

    if (req_fire) pc_next = pc_reg + XLEN'(4);

    unique case (state_reg)
      BOOT:  state_next = RUN;
      RUN:   state_next = RUN;
      FLUSH: begin
        if (i_im_rvalid && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
        if (drop_next == '0) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase

    // Everything still in flight after this cycle belongs to the old stream.
    if (i_redirect_valid) begin
      pc_next         = {i_redirect_pc[XLEN-1:2], 2'b00};
      misaligned_next = |i_redirect_pc[1:0];
      drop_next       = outstanding_next;
      state_next      = (outstanding_next != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      misaligned_reg  <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      misaligned_reg  <= misaligned_next;
    end
  end

  // Live tags exist only outside a flush, and then match the in-flight count.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ((drop_reg != '0) ? (tag_count == '0) : (tag_count == outstanding_reg));
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: memory model with programmable latency, a scoreboard
// of expected {pc, instr} pushed at request acceptance and popped on
// delivery, hand-written timing sequences and a table of redirect vectors.
module tb_instruction_fetch;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            o_im_req_valid;
  logic            i_im_req_ready;
  logic [XLEN-1:0] o_im_addr;
  logic            i_im_rvalid;
  logic [XLEN-1:0] i_im_rdata;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_if_valid;
  logic            i_if_ready;
  logic [XLEN-1:0] o_if_instr;
  logic [XLEN-1:0] o_if_pc;
  logic            o_misaligned;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .o_im_req_valid   (o_im_req_valid),
    .i_im_req_ready   (i_im_req_ready),
    .o_im_addr        (o_im_addr),
    .i_im_rvalid      (i_im_rvalid),
    .i_im_rdata       (i_im_rdata),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_if_valid       (o_if_valid),
    .i_if_ready       (i_if_ready),
    .o_if_instr       (o_if_instr),
    .o_if_pc          (o_if_pc),
    .o_misaligned     (o_misaligned)
  );

  typedef struct { logic [31:0] addr; int due; bit live; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] target; logic exp_mis; logic [31:0] exp_restart; } redir_vec_t;

  mreq_t mq[$];
  exp_t  sb[$];
  redir_vec_t vecs[5];

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc, last_due, buf_cnt, pop_total;
  int lat_lo, lat_hi, req_pct, if_pct;
  logic [31:0] model_pc;
  bit          exp_mis;
  bit          redir_now;
  logic [31:0] redir_target;
  bit          obs_hs, obs_rv, obs_pop, obs_req_valid, obs_if_valid, obs_mis;
  logic [31:0] obs_if_pc, obs_hs_addr;
  bit          await_hs;
  logic [31:0] cap_addr;
  int          cap_cycle;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, observe 1 time
  // unit later, update the models, then wait for the next falling edge.
  task automatic tick();
    mreq_t r;
    exp_t  e;
    int    inflight, lat, due;
    bit    rsp_live;
    inflight = mq.size();
    rsp_live = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      i_im_rvalid = 1'b1;
      i_im_rdata  = instr_of(r.addr);
      rsp_live    = r.live;
    end else begin
      i_im_rvalid = 1'b0;
      i_im_rdata  = $urandom;
    end
    i_im_req_ready   = ($urandom_range(99) < req_pct);
    i_if_ready       = ($urandom_range(99) < if_pct);
    i_redirect_valid = redir_now;
    i_redirect_pc    = redir_target;
    #1;
    obs_rv        = i_im_rvalid;
    obs_req_valid = o_im_req_valid;
    obs_if_valid  = o_if_valid;
    obs_if_pc     = o_if_pc;
    obs_mis       = o_misaligned;
    check("if_valid_vs_model", 32'(o_if_valid), 32'(buf_cnt != 0));
    check("misaligned", 32'(o_misaligned), 32'(exp_mis));
    if (o_im_req_valid) check("credit", 32'(inflight + buf_cnt < DEPTH), 32'd1);

    obs_pop = o_if_valid && i_if_ready;
    if (obs_pop) begin
      pop_total++;
      check("delivery_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("deliver_pc", o_if_pc, e.pc);
        check("deliver_instr", o_if_instr, e.instr);
        $display("cycle %0d deliver pc=%h instr=%h", cyc, o_if_pc, o_if_instr);
      end
    end

    obs_hs = o_im_req_valid && i_im_req_ready;
    if (obs_hs) begin
      obs_hs_addr = o_im_addr;
      check("req_addr", o_im_addr, model_pc);
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr = o_im_addr;
      r.due  = due;
      r.live = !redir_now;
      mq.push_back(r);
      if (!redir_now) begin
        e.pc    = model_pc;
        e.instr = instr_of(model_pc);
        sb.push_back(e);
      end
      model_pc = model_pc + 32'd4;
      if (await_hs) begin
        await_hs  = 1'b0;
        cap_addr  = o_im_addr;
        cap_cycle = cyc;
      end
    end

    if (obs_pop) buf_cnt--;
    if (obs_rv && rsp_live && !redir_now) buf_cnt++;
    exp_mis = redir_now ? (|redir_target[1:0]) : 1'b0;
    if (redir_now) begin
      buf_cnt = 0;
      sb.delete();
      foreach (mq[i]) mq[i].live = 1'b0;
      model_pc = {redir_target[31:2], 2'b00};
      await_hs = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_rst            = 1'b1;
    i_im_req_ready   = 1'b0;
    i_im_rvalid      = 1'b0;
    i_im_rdata       = '0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_if_ready       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(o_im_req_valid), 32'd0);
    check("rst_if_valid", 32'(o_if_valid), 32'd0);
    check("rst_misaligned", 32'(o_misaligned), 32'd0);
    check("rst_if_instr", o_if_instr, 32'd0);
    check("rst_if_pc", o_if_pc, 32'd0);
    mq.delete();
    sb.delete();
    buf_cnt   = 0;
    model_pc  = 32'h0000_0000;
    last_due  = -1;
    cyc       = 0;
    redir_now = 1'b0;
    await_hs  = 1'b0;
    exp_mis   = 1'b0;
    i_rst     = 1'b0;
  endtask

  task automatic wait_capture(input string name, input int budget);
    int n;
    n = 0;
    while (await_hs && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(await_hs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt, vseen, pops0;
    bit got;
    logic [31:0] first_pc;

    vecs[0] = '{32'h0000_0102, 1'b1, 32'h0000_0100};
    vecs[1] = '{32'h0000_0203, 1'b1, 32'h0000_0200};
    vecs[2] = '{32'h0000_1000, 1'b0, 32'h0000_1000};
    vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0000_0055, 1'b1, 32'h0000_0054};
    pop_total    = 0;
    redir_target = '0;
    @(negedge clk);

    // Streaming at L=1 with no backpressure.
    do_reset();
    lat_lo = 1; lat_hi = 1; req_pct = 100; if_pct = 100;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) check("boot_no_req", 32'(obs_req_valid), 32'd0);
      if (c >= 1) check("req_every_cycle", 32'(obs_hs), 32'd1);
      if (c == 2) check("if_valid_c2", 32'(obs_if_valid), 32'd0);
      if (c == 3) begin
        check("if_valid_c3", 32'(obs_if_valid), 32'd1);
        check("if_pc_c3", obs_if_pc, 32'd0);
      end
      if (c >= 3) check("deliver_every_cycle", 32'(obs_pop), 32'd1);
    end

    // Decode stalled: credit stops fetching after DEPTH requests.
    do_reset();
    lat_lo = 1; lat_hi = 1; req_pct = 100; if_pct = 0;
    hs_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      hs_cnt += int'(obs_hs);
    end
    check("accepted_while_stalled", 32'(hs_cnt), 32'd4);
    check("req_valid_stalled", 32'(obs_req_valid), 32'd0);
    if_pct = 100;
    await_hs = 1'b1;
    wait_capture("resume", 20);
    check("resume_addr", cap_addr, 32'h0000_0010);
    repeat (6) tick();

    // Redirect with two requests in flight at L=3.
    do_reset();
    lat_lo = 3; lat_hi = 3; req_pct = 100; if_pct = 100;
    repeat (3) tick();
    req_pct = 0; redir_now = 1'b1; redir_target = 32'h0000_0100;
    tick();
    redir_now = 1'b0; req_pct = 100;
    vseen = 0;
    while (await_hs && cyc < 20) begin
      tick();
      vseen += int'(obs_if_valid);
    end
    check("flush2_timeout", 32'(await_hs), 32'd0);
    check("flush2_if_valid_seen", 32'(vseen), 32'd0);
    check("flush2_restart_cycle", 32'(cap_cycle), 32'd6);
    check("flush2_restart_addr", cap_addr, 32'h0000_0100);
    got = 1'b0; first_pc = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (obs_pop && !got) begin got = 1'b1; first_pc = obs_if_pc; end
    end
    check("flush2_first_delivery_seen", 32'(got), 32'd1);
    check("flush2_first_pc", first_pc, 32'h0000_0100);

    // Redirect coinciding with a handshake and a response at L=3.
    do_reset();
    lat_lo = 3; lat_hi = 3; req_pct = 100; if_pct = 100;
    repeat (4) tick();
    redir_now = 1'b1; redir_target = 32'h0000_0200;
    tick();
    redir_now = 1'b0;
    check("coincide_hs", 32'(obs_hs), 32'd1);
    check("coincide_rv", 32'(obs_rv), 32'd1);
    wait_capture("coincide", 20);
    check("coincide_restart_cycle", 32'(cap_cycle), 32'd8);
    check("coincide_restart_addr", cap_addr, 32'h0000_0200);
    repeat (8) tick();

    // Redirect vectors under random backpressure.
    do_reset();
    lat_lo = 1; lat_hi = 4; req_pct = 70; if_pct = 70;
    for (int i = 0; i < 5; i++) begin
      repeat (6) tick();
      redir_now = 1'b1; redir_target = vecs[i].target;
      tick();
      redir_now = 1'b0;
      tick();
      check("vec_misaligned_flag", 32'(obs_mis), 32'(vecs[i].exp_mis));
      tick();
      check("vec_misaligned_clear", 32'(obs_mis), 32'd0);
      wait_capture("vec_restart", 40);
      check("vec_restart_addr", cap_addr, vecs[i].exp_restart);
    end

    // Random backpressure, latencies and redirects.
    do_reset();
    lat_lo = 1; lat_hi = 4; req_pct = 60; if_pct = 60;
    pops0 = pop_total;
    for (int c = 0; c < 500; c++) begin
      redir_now = ($urandom_range(99) < 3);
      redir_target = $urandom;
      tick();
    end
    redir_now = 1'b0;
    check("random_progress", 32'((pop_total - pops0) >= 40), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
